router_fsm: RTL and testbench

- Packet-sequencing controller for the 1x3 router.
- Watches the incoming byte stream (pkt_valid, header address bits) and the per-port FIFO status.
- Decides when the header, payload and parity bytes may be written into the selected router_fifo, stalls on FIFO full, and waits on a busy destination FIFO.
- Sits between the input synchroniser/register block and the three router_fifo instances. Drives their lfd_state and write-enable sequencing and the parity-check strobe.

---
 rtl/router_pkg.sv | 16 +
 rtl/router_fsm.sv | 69 ++++++
 tb/tb_router_fsm.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the 1x3 router packet sequencer
package router_pkg;
  localparam int NUM_PORTS = 3;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;
  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;
endpackage

// File: rtl/router_fsm.sv
// router_fsm: sequences header/payload/parity writes of the 1x3 router into the addressed FIFO
// ports: clk, resetn (async active-low); pkt_valid, data_in (header address), fifo_full (addressed FIFO),
//        fifo_empty/soft_rst (per port), parity_done, low_pkt_valid in;
//        busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg out (Moore)
module router_fsm
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_rst,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 busy,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg
);
  state_t state, nxt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic hdr_ok;
  assign hdr_ok = pkt_valid && data_in != INVALID_ADDR && int'(data_in) < NUM_PORTS;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= DA;
      addr_q <= '0;
    end else begin
      state  <= nxt;
      addr_q <= addr_d;
    end
  end
  always_comb begin
    nxt    = state;
    addr_d = addr_q;
    case (state)
      DA: if (hdr_ok) begin
        addr_d = data_in;
        nxt    = fifo_empty[data_in] ? LFD : WTE;
      end
      WTE: nxt = fifo_empty[addr_q] ? LFD : WTE;
      LFD: nxt = LD;
      LD:  nxt = fifo_full ? FFS : (!pkt_valid ? LP : LD);
      FFS: nxt = fifo_full ? FFS : LAF;
      LAF: nxt = parity_done ? DA : (low_pkt_valid ? LP : LD);
      LP:  nxt = CPE;
      CPE: nxt = fifo_full ? FFS : DA;
      default: nxt = DA;
    endcase
    // a read timeout on the packet's own port abandons it from any active state
    if (state != DA && soft_rst[addr_q]) nxt = DA;
  end
  always_comb begin
    detect_add    = state == DA;
    lfd_state     = state == LFD;
    ld_state      = state == LD;
    laf_state     = state == LAF;
    full_state    = state == FFS;
    rst_int_reg   = state == CPE;
    write_enb_reg = state == LFD || state == LD || state == LP || state == LAF;
    busy          = !(state == DA || state == LD);
  end
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed self-checking bench for router_fsm
module tb_router_fsm;
  import router_pkg::*;
  logic clk = 0;
  logic resetn = 0;
  logic pkt_valid = 0;
  logic [ADDR_W-1:0] data_in = '0;
  logic fifo_full = 0;
  logic [NUM_PORTS-1:0] fifo_empty = '0;
  logic [NUM_PORTS-1:0] soft_rst = '0;
  logic parity_done = 0;
  logic low_pkt_valid = 0;
  logic busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg;
  int total = 0;
  int passed = 0;

  router_fsm dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_rst(soft_rst),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outv();
    return {busy, detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg};
  endfunction

  // expected output vector {busy,detect_add,lfd,ld,laf,full,write_enb,rst_int} for a state
  function automatic logic [7:0] exp_out(state_t s);
    case (s)
      DA:      return 8'b0100_0000;
      LFD:     return 8'b1010_0010;
      LD:      return 8'b0001_0010;
      FFS:     return 8'b1000_0100;
      LAF:     return 8'b1000_1010;
      LP:      return 8'b1000_0010;
      CPE:     return 8'b1000_0001;
      default: return 8'b1000_0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    resetn = 0;
    pkt_valid = 0; data_in = '0; fifo_full = 0; fifo_empty = '0;
    soft_rst = '0; parity_done = 0; low_pkt_valid = 0;
    @(posedge clk);
    #1;
    resetn = 1;
  endtask

  task automatic test_reset();
    reset_dut();
    total++;
    if (outv() !== exp_out(DA)) $display("FAIL reset_state got=%b exp=%b", outv(), exp_out(DA));
    else passed++;
    fifo_empty = 3'b111; pkt_valid = 1; data_in = 2'd1;
    tick();
    tick();
    total++;
    if (outv() !== exp_out(LD)) $display("FAIL reset_reach_ld got=%b exp=%b", outv(), exp_out(LD));
    else passed++;
    #2 resetn = 0;
    #1;
    total++;
    if (outv() !== exp_out(DA)) $display("FAIL reset_async got=%b exp=%b", outv(), exp_out(DA));
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (outv() !== exp_out(DA)) $display("FAIL reset_held got=%b exp=%b", outv(), exp_out(DA));
    else passed++;
    resetn = 1;
  endtask

  task automatic test_basic();
    state_t seq [8] = '{LFD, LD, LD, LD, LD, LP, CPE, DA};
    int lfd_n = 0, we_n = 0, ri_n = 0;
    reset_dut();
    fifo_empty = 3'b111; data_in = 2'd1;
    for (int k = 0; k < 8; k++) begin
      pkt_valid = k < 5;
      tick();
      total++;
      if (outv() !== exp_out(seq[k])) $display("FAIL basic_step%0d got=%b exp=%b", k, outv(), exp_out(seq[k]));
      else passed++;
      lfd_n += int'(lfd_state);
      we_n  += int'(write_enb_reg);
      ri_n  += int'(rst_int_reg);
    end
    total++;
    if (lfd_n !== 1) $display("FAIL basic_lfd_cycles got=%0d exp=1", lfd_n);
    else passed++;
    total++;
    if (we_n !== 6) $display("FAIL basic_we_cycles got=%0d exp=6", we_n);
    else passed++;
    total++;
    if (ri_n !== 1) $display("FAIL basic_rst_int_cycles got=%0d exp=1", ri_n);
    else passed++;
  endtask

  task automatic test_busy();
    reset_dut();
    fifo_empty = 3'b011; pkt_valid = 1; data_in = 2'd2;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (outv() !== exp_out(WTE)) $display("FAIL busy_wte%0d got=%b exp=%b", k, outv(), exp_out(WTE));
      else passed++;
    end
    fifo_empty = 3'b111;
    tick();
    total++;
    if (outv() !== exp_out(LFD)) $display("FAIL busy_to_lfd got=%b exp=%b", outv(), exp_out(LFD));
    else passed++;
  endtask

  task automatic test_full(input logic lpv, input logic pd, input state_t after);
    reset_dut();
    fifo_empty = 3'b111; pkt_valid = 1; data_in = 2'd0;
    tick();
    tick();
    fifo_full = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (outv() !== exp_out(FFS)) $display("FAIL full_ffs%0d got=%b exp=%b", k, outv(), exp_out(FFS));
      else passed++;
    end
    fifo_full = 0; low_pkt_valid = lpv; parity_done = pd;
    tick();
    total++;
    if (outv() !== exp_out(LAF)) $display("FAIL full_laf got=%b exp=%b", outv(), exp_out(LAF));
    else passed++;
    tick();
    total++;
    if (outv() !== exp_out(after)) $display("FAIL full_after_laf lpv=%b pd=%b got=%b exp=%b", lpv, pd, outv(), exp_out(after));
    else passed++;
  endtask

  task automatic test_invalid();
    reset_dut();
    fifo_empty = 3'b111; pkt_valid = 1; data_in = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (outv() !== exp_out(DA)) $display("FAIL invalid_da%0d got=%b exp=%b", k, outv(), exp_out(DA));
      else passed++;
    end
  endtask

  task automatic test_soft_rst();
    reset_dut();
    fifo_empty = 3'b000; pkt_valid = 1; data_in = 2'd0; soft_rst = 3'b001;
    tick();
    total++;
    if (outv() !== exp_out(WTE)) $display("FAIL soft_ignored_in_da got=%b exp=%b", outv(), exp_out(WTE));
    else passed++;
    soft_rst = 3'b010;
    tick();
    total++;
    if (outv() !== exp_out(WTE)) $display("FAIL soft_other_port got=%b exp=%b", outv(), exp_out(WTE));
    else passed++;
    soft_rst = 3'b001;
    tick();
    total++;
    if (outv() !== exp_out(DA)) $display("FAIL soft_own_port got=%b exp=%b", outv(), exp_out(DA));
    else passed++;
  endtask

  task automatic test_simultaneous();
    reset_dut();
    fifo_empty = 3'b111; pkt_valid = 1; data_in = 2'd0;
    tick();
    tick();
    pkt_valid = 0; fifo_full = 1;
    tick();
    total++;
    if (outv() !== exp_out(FFS)) $display("FAIL sim_full_beats_lp got=%b exp=%b", outv(), exp_out(FFS));
    else passed++;
    fifo_full = 0; low_pkt_valid = 1;
    tick();
    tick();
    total++;
    if (outv() !== exp_out(LP)) $display("FAIL sim_laf_to_lp got=%b exp=%b", outv(), exp_out(LP));
    else passed++;
    low_pkt_valid = 0;
    tick();
    total++;
    if (outv() !== exp_out(CPE)) $display("FAIL sim_cpe got=%b exp=%b", outv(), exp_out(CPE));
    else passed++;
    fifo_full = 1;
    tick();
    total++;
    if (outv() !== exp_out(FFS)) $display("FAIL sim_cpe_to_ffs got=%b exp=%b", outv(), exp_out(FFS));
    else passed++;
    soft_rst = 3'b001;
    tick();
    total++;
    if (outv() !== exp_out(DA)) $display("FAIL sim_soft_beats_full got=%b exp=%b", outv(), exp_out(DA));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_full(1'b1, 1'b0, LP);
    test_full(1'b0, 1'b0, LD);
    test_full(1'b0, 1'b1, DA);
    test_invalid();
    test_soft_rst();
    test_simultaneous();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
